// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared chunk-width helper and stage control record for pipe_adder.
package pipe_adder_pkg;
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;
endpackage

// File: rtl/fa_cell.sv
// fa_cell: one-bit full adder built from xor/and/or gates.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (p & ci);
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined ripple-carry adder, one chunk per stage, valid/ready both sides.
// Define ADD_SUB_EN to add a sub input that turns the operation into a - b.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = chunk_width(WIDTH, STAGES);
  stage_ctl_t       ctl_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];
  logic [CW-1:0]    sc [STAGES];
  logic [CW:0]      c [STAGES];
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             ovf_q;
  logic             adv;
  logic             unused_rem;
`ifdef ADD_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub | cin;
`else
  assign b_eff = b;
  assign c_eff = cin;
`endif
  assign adv        = !ctl_q[STAGES-1].valid || out_ready;
  assign in_ready   = adv;
  assign out_valid  = ctl_q[STAGES-1].valid;
  assign sum        = s_q[STAGES-1];
  assign cout       = ctl_q[STAGES-1].carry;
  assign ovf        = ovf_q;
  // the last stage has no higher chunks left to forward
  assign unused_rem = ^{a_q[STAGES-1], b_q[STAGES-1]};
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    if (k == 0) begin : g_src
      assign a_in[k] = a;
      assign b_in[k] = b_eff;
      assign c_in[k] = c_eff;
      assign v_in[k] = in_valid;
      assign s_in[k] = '0;
    end else begin : g_src
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = ctl_q[k-1].carry;
      assign v_in[k] = ctl_q[k-1].valid;
      assign s_in[k] = s_q[k-1];
    end
    assign c[k][0] = c_in[k];
    for (genvar i = 0; i < CW; i++) begin : g_bit
      fa_cell u_fa (
        .a (a_in[k][k*CW+i]),
        .b (b_in[k][k*CW+i]),
        .ci(c[k][i]),
        .s (sc[k][i]),
        .co(c[k][i+1])
      );
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        ctl_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
      end else if (adv) begin
        ctl_q[k]             <= '{valid: v_in[k], carry: c[k][CW]};
        a_q[k]               <= a_in[k];
        b_q[k]               <= b_in[k];
        s_q[k]               <= s_in[k];
        s_q[k][k*CW +: CW]   <= sc[k];
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_q <= 1'b0;
    else if (adv) ovf_q <= c[STAGES-1][CW] ^ c[STAGES-1][CW-1];
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed vectors plus stream, stall and reset sequences for pipe_adder.
module tb_pipe_adder;
  localparam int W = 16;
  localparam int S = 4;
  logic         clk = 0;
  logic         rst_n = 0;
  logic         in_valid = 0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 0;
`ifdef ADD_SUB_EN
  logic         sub = 0;
`endif
  logic         out_valid;
  logic         out_ready = 1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;
  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } res_t;
  vec_t tv [8];
  res_t q [$];
  always #5 clk = ~clk;
  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef ADD_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic ci);
    logic [16:0] t;
    res_t r;
    t = {1'b0, x} + {1'b0, y} + {16'b0, ci};
    r.s = t[15:0];
    r.co = t[16];
    r.ov = (x[15] == y[15]) && (t[15] != x[15]);
    return r;
  endfunction
  task automatic single(input logic [15:0] x, input logic [15:0] y, input logic ci,
                        output int lat, output logic [15:0] s, output logic co, output logic ov);
    a = x;
    b = y;
    cin = ci;
    in_valid = 1;
    step;
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step;
      lat++;
    end
    s = sum;
    co = cout;
    ov = ovf;
    step;
  endtask
  initial begin
    int lat, acc, t, last;
    logic [15:0] s;
    logic co, ov;
    logic [15:0] held;
    res_t r, e;
    tv[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    tv[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tv[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tv[4] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    tv[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tv[6] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tv[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_sum", {16'b0, sum}, 0);
    chk("rst_cout", {31'b0, cout}, 0);
    chk("rst_ovf", {31'b0, ovf}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    rst_n = 1;
    step;
    for (int i = 0; i < 8; i++) begin
      single(tv[i].a, tv[i].b, tv[i].ci, lat, s, co, ov);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_sum", i), {16'b0, s}, {16'b0, tv[i].s});
      chk($sformatf("vec%0d_cout", i), {31'b0, co}, {31'b0, tv[i].co});
      chk($sformatf("vec%0d_ovf", i), {31'b0, ov}, {31'b0, tv[i].ov});
    end
    acc = 0;
    t = 0;
    last = 0;
    for (int n = 0; n < 8 && t < 40; t++) begin
      if (acc < 8) begin
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
        in_valid = 1;
      end else in_valid = 0;
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin));
        acc++;
      end
      step;
      if (out_valid) begin
        e = q.pop_front();
        r = '{sum, cout, ovf};
        chk($sformatf("stream%0d_result", n), {13'b0, r}, {13'b0, e});
        if (n > 0) chk($sformatf("stream%0d_gap", n), t - last, 1);
        last = t;
        n++;
      end
    end
    in_valid = 0;
    chk("stream_left", q.size(), 0);
    q.delete();
    step;
    out_ready = 0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      a = 16'(16'h1111 * (i + 1));
      b = 16'(i);
      cin = 0;
      in_valid = 1;
      if (in_ready) begin
        q.push_back(model(a, b, cin));
        acc++;
      end
      step;
    end
    in_valid = 0;
    chk("stall_accepts", acc, 4);
    chk("stall_in_ready", {31'b0, in_ready}, 0);
    chk("stall_out_valid", {31'b0, out_valid}, 1);
    held = sum;
    step;
    step;
    chk("stall_hold", {16'b0, sum}, {16'b0, held});
    out_ready = 1;
    t = 0;
    last = 0;
    acc = 0;
    while (q.size() > 0 && t < 20) begin
      if (out_valid) begin
        e = q.pop_front();
        r = '{sum, cout, ovf};
        chk($sformatf("drain%0d_result", acc), {13'b0, r}, {13'b0, e});
        if (acc > 0) chk($sformatf("drain%0d_gap", acc), t - last, 1);
        last = t;
        acc++;
      end
      step;
      t++;
    end
    chk("drain_count", acc, 4);
    q.delete();
    step;
    for (int i = 0; i < 3; i++) begin
      a = 16'h0101;
      b = 16'h0202;
      cin = 0;
      in_valid = 1;
      step;
    end
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 0);
    chk("midrst_sum", {16'b0, sum}, 0);
    #2;
    rst_n = 1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      step;
      if (out_valid) acc++;
    end
    chk("midrst_stale", acc, 0);
    single(16'h00FF, 16'h0001, 1'b0, lat, s, co, ov);
    chk("postrst_latency", lat, 4);
    chk("postrst_sum", {16'b0, s}, 32'h0100);
`ifdef ADD_SUB_EN
    sub = 1;
    single(16'h0005, 16'h0007, 1'b0, lat, s, co, ov);
    chk("sub1_sum", {16'b0, s}, 32'hFFFE);
    chk("sub1_cout", {31'b0, co}, 0);
    single(16'h8000, 16'h0001, 1'b0, lat, s, co, ov);
    chk("sub2_sum", {16'b0, s}, 32'h7FFF);
    chk("sub2_ovf", {31'b0, ov}, 1);
    chk("sub2_cout", {31'b0, co}, 1);
    sub = 0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
